// File: rtl/upscale_ctrl_if.sv
// Bus bundle for the nearest-neighbour upscaler: sequencer
// handshake plus ROM read and RAM write ports.
interface upscale_ctrl_if #(
  parameter int SRC_W_LOG2 = 7,
  parameter int SRC_H_LOG2 = 7,
  parameter int DW         = 8
);
  localparam int AW = SRC_W_LOG2 + SRC_H_LOG2;

  logic          start;
  logic [1:0]    scale_sel;
  logic          busy;
  logic          done;
  logic [AW-1:0] ROM_A;
  logic          ROM_OE;
  logic [DW-1:0] ROM_Q;
  logic [AW+3:0] RAM_A;
  logic [DW-1:0] RAM_D;
  logic          RAM_WE;

  modport master (
    input  start,
    input  scale_sel,
    input  ROM_Q,
    output busy,
    output done,
    output ROM_A,
    output ROM_OE,
    output RAM_A,
    output RAM_D,
    output RAM_WE
  );

  modport slave (
    output start,
    output scale_sel,
    output ROM_Q,
    input  busy,
    input  done,
    input  ROM_A,
    input  ROM_OE,
    input  RAM_A,
    input  RAM_D,
    input  RAM_WE
  );
endinterface

// File: rtl/upscale_ctrl.sv
// Nearest-neighbour 1x/2x/4x upscaler: ROM source to RAM raster.
// Optional UPSCALE_REUSE_EN skips ROM reads for repeated source pixels.
module upscale_ctrl #(
  parameter int SRC_W_LOG2 = 7,
  parameter int SRC_H_LOG2 = 7,
  parameter int DW         = 8,
  parameter int ROM_LAT    = 1
) (
  input logic clk,
  input logic rst,
  upscale_ctrl_if.master bus
);
  localparam int SW = SRC_W_LOG2;
  localparam int SH = SRC_H_LOG2;
  localparam int XW = SW + 2;
  localparam int YW = SH + 2;
  localparam int AW = SW + SH;
  localparam int RW = AW + 4;
  localparam int CW = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t        state, nstate;
  logic [1:0]    k, k_n;
  logic [XW-1:0] x, x_n, xmax;
  logic [YW-1:0] y, y_n, ymax;
  logic [CW-1:0] wcnt, wcnt_n;
  logic          last_x, last_y;
  logic          reuse_hit;

  logic [AW-1:0] rom_a, rom_a_n;
  logic          rom_oe;
  logic [RW-1:0] ram_a, ram_a_n;
  logic [DW-1:0] ram_d, ram_d_n;
  logic          ram_we;
  logic          busy, done;

  assign xmax   = {XW{1'b1}} >> (2'd2 - k);
  assign ymax   = {YW{1'b1}} >> (2'd2 - k);
  assign last_x = (x == xmax);
  assign last_y = (y == ymax);

  // Next column shares the source pixel unless its low k bits wrap.
`ifdef UPSCALE_REUSE_EN
  assign reuse_hit = ((k == 2'd1) && !x[0]) ||
                     ((k == 2'd2) && (x[1:0] != 2'b11));
`else
  assign reuse_hit = 1'b0;
`endif

  always_comb begin
    nstate  = state;
    k_n     = k;
    x_n     = x;
    y_n     = y;
    wcnt_n  = wcnt;
    ram_d_n = ram_d;
    unique case (state)
      IDLE: begin
        if (bus.start && (bus.scale_sel != 2'd3)) begin
          nstate = READ;
          k_n    = bus.scale_sel;
          x_n    = '0;
          y_n    = '0;
        end
      end
      READ: begin
        wcnt_n = '0;
        nstate = (ROM_LAT > 1) ? WAIT : WRITE;
      end
      WAIT: begin
        if (wcnt == CW'(ROM_LAT - 2)) begin
          nstate = WRITE;
        end else begin
          wcnt_n = wcnt + 1'b1;
        end
      end
      WRITE: begin
        if (last_x) begin
          x_n = '0;
          if (last_y) begin
            nstate = DONE;
          end else begin
            y_n    = y + 1'b1;
            nstate = READ;
          end
        end else begin
          x_n    = x + 1'b1;
          nstate = reuse_hit ? WRITE : READ;
        end
      end
      DONE: begin
        nstate = IDLE;
      end
      default: begin
        nstate = IDLE;
      end
    endcase
    if ((nstate == WRITE) && (state != WRITE)) begin
      ram_d_n = bus.ROM_Q;
    end
  end

  // Addresses are precomputed from next-cycle counters so outputs stay registered.
  always_comb begin
    rom_a_n = {SH'(y_n >> k_n), SW'(x_n >> k_n)};
    ram_a_n = (RW'(y_n) << (SW + int'(k_n))) | RW'(x_n);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= 2'd0;
      x      <= '0;
      y      <= '0;
      wcnt   <= '0;
      rom_a  <= '0;
      rom_oe <= 1'b0;
      ram_a  <= '0;
      ram_d  <= '0;
      ram_we <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= nstate;
      k      <= k_n;
      x      <= x_n;
      y      <= y_n;
      wcnt   <= wcnt_n;
      rom_a  <= rom_a_n;
      rom_oe <= (nstate == READ) || (nstate == WAIT);
      ram_a  <= ram_a_n;
      ram_d  <= ram_d_n;
      ram_we <= (nstate == WRITE);
      busy   <= (nstate == READ) || (nstate == WAIT) ||
                (nstate == WRITE);
      done   <= (nstate == DONE);
    end
  end

  assign bus.ROM_A  = rom_a;
  assign bus.ROM_OE = rom_oe;
  assign bus.RAM_A  = ram_a;
  assign bus.RAM_D  = ram_d;
  assign bus.RAM_WE = ram_we;
  assign bus.busy   = busy;
  assign bus.done   = done;
endmodule

// File: tb/tb_upscale_ctrl.sv
// Randomised bench for upscale_ctrl against a raster-loop model,
// covering ROM latency 1 and 3 on a reduced source image.
module tb_upscale_ctrl;
  localparam int SW = 5;
  localparam int SH = 4;
  localparam int DW = 8;
  localparam int W  = 1 << SW;
  localparam int H  = 1 << SH;
  localparam int AW = SW + SH;
`ifdef UPSCALE_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] scale_sel = 2'd0;
  logic sel3 = 1'b0;

  always #5 clk = ~clk;

  upscale_ctrl_if #(.SRC_W_LOG2(SW), .SRC_H_LOG2(SH), .DW(DW)) if1 ();
  upscale_ctrl_if #(.SRC_W_LOG2(SW), .SRC_H_LOG2(SH), .DW(DW)) if3 ();

  upscale_ctrl #(.SRC_W_LOG2(SW), .SRC_H_LOG2(SH), .DW(DW), .ROM_LAT(1))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  upscale_ctrl #(.SRC_W_LOG2(SW), .SRC_H_LOG2(SH), .DW(DW), .ROM_LAT(3))
    u3 (.clk(clk), .rst(rst), .bus(if3));

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] d1, d2;

  assign if1.start     = start & ~sel3;
  assign if3.start     = start & sel3;
  assign if1.scale_sel = scale_sel;
  assign if3.scale_sel = scale_sel;
  assign if1.ROM_Q     = mem[if1.ROM_A];
  assign if3.ROM_Q     = mem[d2];

  // Latency-3 ROM: data for an address appears two edges after it is driven.
  always @(posedge clk) begin
    d1 <= if3.ROM_A;
    d2 <= d1;
  end

  logic          s_we, s_oe, s_busy, s_done;
  logic [AW+3:0] s_ram_a;
  logic [AW-1:0] s_rom_a;
  logic [DW-1:0] s_d, s_q;
  assign s_we    = sel3 ? if3.RAM_WE : if1.RAM_WE;
  assign s_oe    = sel3 ? if3.ROM_OE : if1.ROM_OE;
  assign s_busy  = sel3 ? if3.busy   : if1.busy;
  assign s_done  = sel3 ? if3.done   : if1.done;
  assign s_ram_a = sel3 ? if3.RAM_A  : if1.RAM_A;
  assign s_rom_a = sel3 ? if3.ROM_A  : if1.ROM_A;
  assign s_d     = sel3 ? if3.RAM_D  : if1.RAM_D;
  assign s_q     = sel3 ? if3.ROM_Q  : if1.ROM_Q;

  int checks = 0;
  int failures = 0;

  int exp_a[$];
  int exp_d[$];
  int exp_c[$];
  int e_done, e_reads, e_writes;
  int f_writes, f_bad, f_done, f_dones, f_reads;
  int f_busy_bad, f_max, f_eq_bad, f_q_bad, f_first_a;
  int f_pa, f_pd, f_pra;

  task automatic build_model(input int lat, input int k);
    int cyc, prev_sx, sx, sy, dw, dh;
    exp_a.delete();
    exp_d.delete();
    exp_c.delete();
    dw = W * (1 << k);
    dh = H * (1 << k);
    cyc = 0;
    e_reads = 0;
    prev_sx = -1;
    for (int dy = 0; dy < dh; dy++) begin
      for (int dx = 0; dx < dw; dx++) begin
        sx = dx / (1 << k);
        sy = dy / (1 << k);
        if (!REUSE || dx == 0 || sx != prev_sx) begin
          cyc += lat + 1;
          e_reads++;
        end else begin
          cyc += 1;
        end
        prev_sx = sx;
        exp_a.push_back(dy * dw + dx);
        exp_d.push_back(int'(mem[sy * W + sx]));
        exp_c.push_back(cyc);
      end
    end
    e_done = cyc + 1;
    e_writes = dw * dh;
  endtask

  task automatic run_frame(input bit l3, input logic [1:0] sel,
                           input bit noise, input int probe);
    int idx, rise, q_samp, lim;
    bit oe_prev;
    sel3 = l3;
    build_model(l3 ? 3 : 1, int'(sel));
    f_writes = 0; f_bad = 0; f_done = -1; f_dones = 0;
    f_reads = 0; f_busy_bad = 0; f_max = -1; f_eq_bad = 0;
    f_q_bad = 0; f_first_a = -1; f_pa = -1; f_pd = -1; f_pra = -1;
    idx = 0; rise = -100; q_samp = -1; oe_prev = 1'b0;
    lim = e_done + 3;
    scale_sel = sel;
    start = 1'b1;
    for (int cyc = 1; cyc <= lim; cyc++) begin
      @(posedge clk);
      #1;
      start = noise && cyc >= 10 && cyc < 30;
      scale_sel = (noise && cyc >= 10 && cyc < 30) ?
                  2'($urandom) : sel;
      if (s_oe && !oe_prev) begin
        f_reads++;
        rise = cyc;
        f_pra = int'(s_rom_a);
      end
      oe_prev = s_oe;
      if (cyc == rise + 2) q_samp = int'(s_q);
      if (s_we) begin
        if (idx == 0) f_first_a = int'(s_ram_a);
        if (idx == probe) begin
          f_pa = int'(s_ram_a);
          f_pd = int'(s_d);
        end
        if (idx >= exp_a.size()) f_bad++;
        else if (int'(s_ram_a) != exp_a[idx] ||
                 int'(s_d) != exp_d[idx] || cyc != exp_c[idx])
          f_bad++;
        if (sel == 2'd0 && int'(s_ram_a) != int'(s_rom_a)) f_eq_bad++;
        if (l3 && int'(s_d) != q_samp) f_q_bad++;
        if (int'(s_ram_a) > f_max) f_max = int'(s_ram_a);
        idx++;
      end
      if (s_busy !== (cyc < e_done)) f_busy_bad++;
      if (s_done) begin
        f_dones++;
        if (f_done < 0) f_done = cyc;
      end
    end
    f_writes = idx;
    start = 1'b0;
    scale_sel = sel;
  endtask

  task automatic check_frame(input string tag);
    checks++;
    if (f_writes !== e_writes) begin
      failures++;
      $display("FAIL %s writes got=%0d want=%0d", tag, f_writes, e_writes);
    end
    checks++;
    if (f_bad !== 0) begin
      failures++;
      $display("FAIL %s write_data got=%0d bad want=0", tag, f_bad);
    end
    checks++;
    if (f_done !== e_done || f_dones !== 1) begin
      failures++;
      $display("FAIL %s done got=%0d x%0d want=%0d x1",
               tag, f_done, f_dones, e_done);
    end
    checks++;
    if (f_reads !== e_reads) begin
      failures++;
      $display("FAIL %s reads got=%0d want=%0d", tag, f_reads, e_reads);
    end
    checks++;
    if (f_busy_bad !== 0) begin
      failures++;
      $display("FAIL %s busy got=%0d bad want=0", tag, f_busy_bad);
    end
    checks++;
    if (f_max !== e_writes - 1) begin
      failures++;
      $display("FAIL %s max_ram_a got=%0d want=%0d",
               tag, f_max, e_writes - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if1.busy, if1.done, if1.RAM_WE, if1.ROM_OE} !== 4'b0 ||
        if1.RAM_A !== '0 || if1.ROM_A !== '0 || if1.RAM_D !== '0 ||
        {if3.busy, if3.done, if3.RAM_WE, if3.ROM_OE} !== 4'b0) begin
      failures++;
      $display("FAIL reset outputs got busy=%b we=%b oe=%b ram_a=%0d want 0",
               if1.busy, if1.RAM_WE, if1.ROM_OE, if1.RAM_A);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_scale1x();
    run_frame(1'b0, 2'd0, 1'b0, -1);
    check_frame("scale1x");
    checks++;
    if (f_eq_bad !== 0) begin
      failures++;
      $display("FAIL scale1x ram_eq_rom got=%0d bad want=0", f_eq_bad);
    end
  endtask

  task automatic test_scale2x();
    int p;
    p = 3 * (2 * W) + 5;
    run_frame(1'b0, 2'd1, 1'b0, p);
    check_frame("scale2x");
    checks++;
    if (f_pa !== 3 * 2 * W + 5 || f_pd !== int'(mem[W + 2])) begin
      failures++;
      $display("FAIL probe_x5y3 got ram_a=%0d d=%0d want ram_a=%0d d=%0d",
               f_pa, f_pd, 3 * 2 * W + 5, mem[W + 2]);
    end
  endtask

  task automatic test_probe_read();
    int p;
    p = 3 * (2 * W) + 5;
    sel3 = 1'b0;
    build_model(1, 1);
    scale_sel = 2'd1;
    start = 1'b1;
    f_pra = -1;
    for (int i = 0; i < e_done + 3; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (if1.RAM_WE && int'(if1.RAM_A) == exp_a[p]) break;
      if (if1.ROM_OE) f_pra = int'(if1.ROM_A);
    end
    checks++;
    if (f_pra !== W + 2) begin
      failures++;
      $display("FAIL probe_rom_a got=%0d want=%0d", f_pra, W + 2);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_scale4x();
    run_frame(1'b0, 2'd2, 1'b0, -1);
    check_frame("scale4x");
  endtask

  task automatic test_lat3();
    run_frame(1'b1, 2'd0, 1'b1, -1);
    check_frame("lat3");
    checks++;
    if (f_q_bad !== 0) begin
      failures++;
      $display("FAIL lat3 rom_q_sample got=%0d bad want=0", f_q_bad);
    end
    run_frame(1'b1, 2'd1, 1'b0, -1);
    check_frame("lat3_2x");
  endtask

  task automatic test_reserved();
    int act;
    sel3 = 1'b0;
    act = 0;
    scale_sel = 2'd3;
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (if1.busy || if1.ROM_OE || if1.RAM_WE || if1.done) act++;
    end
    start = 1'b0;
    scale_sel = 2'd0;
    checks++;
    if (act !== 0) begin
      failures++;
      $display("FAIL reserved_sel got=%0d active want=0", act);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    bit hit;
    sel3 = 1'b0;
    n = 0;
    hit = 1'b0;
    scale_sel = 2'd0;
    start = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (if1.RAM_WE) n++;
      if (n == 100) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL mid_reset_reach got=%0d writes want=100", n);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({if1.busy, if1.done, if1.RAM_WE, if1.ROM_OE} !== 4'b0 ||
        if1.RAM_A !== '0 || if1.ROM_A !== '0 || if1.RAM_D !== '0) begin
      failures++;
      $display("FAIL mid_reset outputs got busy=%b we=%b ram_a=%0d want 0",
               if1.busy, if1.RAM_WE, if1.RAM_A);
    end
    @(posedge clk);
    #1;
    checks++;
    if (if1.RAM_WE !== 1'b0 || if1.busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset hold got we=%b busy=%b want 0 0",
               if1.RAM_WE, if1.busy);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame(1'b0, 2'd0, 1'b0, -1);
    check_frame("restart");
    checks++;
    if (f_first_a !== 0) begin
      failures++;
      $display("FAIL restart first_ram_a got=%0d want=0", f_first_a);
    end
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    test_reset();
    test_scale1x();
    test_scale2x();
    test_probe_read();
    test_scale4x();
    test_lat3();
    test_reserved();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
